// File: rtl/sha1_block_engine.sv
// sha1_block_engine: SHA-1 compression core, UNROLL rounds per clock.
// A 512-bit block arrives as 16 big-endian words over a valid/ready stream.
// The core runs 80 rounds, adds the result into the chaining value it holds,
// and emits the digest, so multi-block messages need no external state.
//   clk, rst_n    clock, async active-low reset
//   din/din_valid/din_ready  message word stream, W0 first
//   first         sampled with word 0: 1 = start from IV, 0 = chain from H
//   digest        H0..H4, H0 in [159:128]; holds until the next block ends
//   digest_valid  one-cycle pulse when digest is updated
//   busy          high while rounds or the feed-forward are in progress

// One SHA-1 round. State word 4 is A and word 0 is E, so the packed
// vector has the same layout as the 160-bit IV/digest.
module sha1_round (
  input  logic [6:0]       t,
  input  logic [4:0][31:0] s_in,
  input  logic [31:0]      w,
  output logic [4:0][31:0] s_out
);
  logic [31:0] a, b, c, d, e, f, k, tmp;

  assign a = s_in[4];
  assign b = s_in[3];
  assign c = s_in[2];
  assign d = s_in[1];
  assign e = s_in[0];

  always_comb begin
    f = b ^ c ^ d;
    k = 32'hca62c1d6;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5a827999;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ed9eba1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8f1bbcdc;
    end
  end

  assign tmp   = {a[26:0], a[31:27]} + f + e + k + w;
  assign s_out = {tmp, a, {b[1:0], b[31:2]}, c, d};
endmodule

module sha1_block_engine #(
  parameter int           UNROLL = 1,
  parameter logic [159:0] IV     = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         first,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy
);
  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
      $error("sha1_block_engine: UNROLL must be 1, 2, 4 or 5");
    end
  endgenerate

  logic [1:0]              state;
  logic [3:0]              cnt;
  logic [6:0]              rnd;
  logic                    ready;
  logic                    dv;
  logic [4:0][31:0]        h;
  logic [4:0][31:0]        work;
  logic [4:0][31:0]        h_new;
  logic [15:0][31:0]       win;      // win[0] is W_t of the current round
  logic [15+UNROLL:0][31:0] ext;     // window plus the UNROLL words it produces
  logic [UNROLL:0][4:0][31:0] st;    // round chain within one edge
  logic                    accept;

  assign accept       = din_valid & ready;
  assign din_ready    = ready;
  assign digest_valid = dv;
  assign busy         = (state != S_LOAD);

  // Message schedule: words beyond the window are built from earlier ones,
  // including words produced earlier in the same edge when UNROLL > 3.
  assign ext[15:0] = win;
  genvar j;
  generate
    for (j = 0; j < UNROLL; j++) begin : g_sched
      logic [31:0] x;
      assign x          = ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j];
      assign ext[16+j]  = {x[30:0], x[31]};
    end
  endgenerate

  assign st[0] = work;
  generate
    for (j = 0; j < UNROLL; j++) begin : g_round
      sha1_round u_round (
        .t     (rnd + 7'(j)),
        .s_in  (st[j]),
        .w     (win[j]),
        .s_out (st[j+1])
      );
    end
  endgenerate

  generate
    for (j = 0; j < 5; j++) begin : g_ff
      assign h_new[j] = h[j] + work[j];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_LOAD;
      cnt    <= '0;
      rnd    <= '0;
      ready  <= 1'b0;
      dv     <= 1'b0;
      digest <= '0;
      h      <= IV;
      work   <= '0;
      win    <= '0;
    end else begin
      dv <= 1'b0;
      case (state)
        S_LOAD: begin
          ready <= 1'b1;
          if (accept) begin
            win <= {din, win[15:1]};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd0) begin
              // Restarting a message resets H so the feed-forward adds IV.
              work <= first ? IV : h;
              if (first) h <= IV;
            end
            if (cnt == 4'd15) begin
              ready <= 1'b0;
              rnd   <= '0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          work <= st[UNROLL];
          win  <= ext[15+UNROLL:UNROLL];
          rnd  <= rnd + 7'(UNROLL);
          if (rnd == 7'(80 - UNROLL)) state <= S_FINAL;
        end
        S_FINAL: begin
          h      <= h_new;
          digest <= h_new;
          dv     <= 1'b1;
          ready  <= 1'b1;
          state  <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_block_engine.sv
// Self-checking bench: four engines (UNROLL 1, 2, 4, 5) fed from one stream.
// Expected digests are queued per engine at send time and compared on each
// digest_valid pulse together with the last-word-to-pulse latency.
module tb_sha1_block_engine;
  localparam int NI = 4;
  localparam logic [159:0] ABC_D   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] EMPTY_D = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] TWO_D   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  typedef struct {
    logic [159:0] dig;
    bit           chk;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [31:0]           din = '0;
  logic                  din_valid = 1'b0;
  logic                  first = 1'b0;
  logic [NI-1:0]         rdy_v, dv_v, busy_v;
  logic [NI-1:0][159:0]  dig_v;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   w15_cyc = 0;
  exp_t exp_q [NI][$];
  logic [15:0][31:0] blk;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ul(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 5;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      sha1_block_engine #(.UNROLL(ul(g))) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (rdy_v[g]),
        .first        (first),
        .digest       (dig_v[g]),
        .digest_valid (dv_v[g]),
        .busy         (busy_v[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, expv);
    end
  endtask

  // Scoreboard and ready-vs-busy monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (dv_v[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("extra_pulse_u%0d", ul(i)), 160'd1, 160'd0);
          end else begin
            e = exp_q[i].pop_front();
            if (e.chk) begin
              chk($sformatf("digest_u%0d", ul(i)), dig_v[i], e.dig);
              chk($sformatf("latency_u%0d", ul(i)), 160'(cyc - w15_cyc), 160'(80 / ul(i) + 1));
            end
          end
        end
        if (busy_v[i]) chk($sformatf("ready_in_busy_u%0d", ul(i)), 160'(rdy_v[i]), 160'd0);
      end
    end
  end

  // Drive one block; the word is offered only when every engine is ready.
  task automatic send_block(input logic [15:0][31:0] b, input bit fst, input int gap_pct,
                            input logic [159:0] expv, input bit push, input bit cmp);
    exp_t e;
    int   n;
    if (push) begin
      e.dig = expv;
      e.chk = cmp;
      for (int i = 0; i < NI; i++) exp_q[i].push_back(e);
    end
    for (int w = 0; w < 16; w++) begin
      n = 0;
      while ($urandom_range(99) < gap_pct && n < 8) begin
        din_valid = 1'b0;
        din       = $urandom;
        @(negedge clk);
        n++;
      end
      n = 0;
      while (!(&rdy_v) && n < 500) begin
        din_valid = 1'b0;
        @(negedge clk);
        n++;
      end
      if (n >= 500) chk("ready_timeout", 160'(rdy_v), 160'({NI{1'b1}}));
      din       = b[w];
      first     = (w == 0) ? fst : 1'($urandom);
      din_valid = 1'b1;
      @(negedge clk);
      if (w == 15) w15_cyc = cyc;
    end
    din_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (n < 2000 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 160'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 160'd0);
    repeat (3) @(negedge clk);
  endtask

  // Called at a falling edge with rst_n already low.
  task automatic reset_checks;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_digest_u%0d", ul(i)), dig_v[i], 160'd0);
      chk($sformatf("rst_dv_u%0d", ul(i)), 160'(dv_v[i]), 160'd0);
      chk($sformatf("rst_busy_u%0d", ul(i)), 160'(busy_v[i]), 160'd0);
      chk($sformatf("rst_ready_u%0d", ul(i)), 160'(rdy_v[i]), 160'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", 160'(rdy_v), 160'd0);
    @(negedge clk);
    chk("ready_after_release", 160'(rdy_v), 160'({NI{1'b1}}));
    chk("digest_after_release", 160'(|dig_v), 160'd0);
  endtask

  initial begin
    reset_checks();

    // "abc", single block
    blk = '0; blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    send_block(blk, 1'b1, 0, ABC_D, 1'b1, 1'b1);
    drain();

    // empty message, with input gaps
    blk = '0; blk[0] = 32'h80000000;
    send_block(blk, 1'b1, 40, EMPTY_D, 1'b1, 1'b1);

    // two-block message: 56 bytes leave no room for the length, so the
    // padding marker ends block 1 and block 2 carries only the length
    blk = '0;
    blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566;
    blk[3]  = 32'h64656667; blk[4]  = 32'h65666768; blk[5]  = 32'h66676869;
    blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b; blk[8]  = 32'h696a6b6c;
    blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
    blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000;
    send_block(blk, 1'b1, 0, '0, 1'b1, 1'b0);
    blk = '0; blk[15] = 32'h000001c0;
    send_block(blk, 1'b0, 0, TWO_D, 1'b1, 1'b1);

    // first=1 while H holds the previous message restarts from IV
    blk = '0; blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    send_block(blk, 1'b1, 50, ABC_D, 1'b1, 1'b1);
    drain();

    // reset while every engine is mid-RUN: no pulse, digest cleared
    send_block(blk, 1'b1, 0, '0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("busy_before_abort", 160'(busy_v), 160'({NI{1'b1}}));
    rst_n = 1'b0;
    reset_checks();
    repeat (100) @(negedge clk);
    chk("no_pulse_after_abort", 160'(|dig_v), 160'd0);

    // first=0 straight after reset chains from IV
    send_block(blk, 1'b0, 30, ABC_D, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
